// File: rtl/alu_operand_seq.sv
// ---------------------------------------------------------------------------
// alu_operand_seq
//   Operand sequencer and writeback stage for the external combinational
//   16-bit ALU. Holds a small register file, accepts one instruction at a
//   time over INSTR_VALID/INSTR_READY, presents registered operands on
//   A/B/CONTROL, and on the following edge writes the ALU result (Z) back
//   into the register file and latches OF/CC into status registers.
//
//   Instruction word: [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt,
//   [2:0] reserved (ignored). op[3]=1 is an illegal op (no writeback).
//
//   Flow: IDLE --accept--> EXEC --> WB (DONE pulse) --> IDLE
//
// Parameters
//   REG_ADDR_W : register address width (depth = 2**REG_ADDR_W x 16 bit)
//   R0_ZERO    : 1 -> register 0 reads as zero, writes to it are dropped
//
// Ports
//   CLK, RST_N            : clock (rising edge), async active-low reset
//   INSTR_VALID/READY/INSTR : instruction handshake and word
//   LD_EN/LD_ADDR/LD_DATA : external register load (honoured in IDLE only)
//   RD_ADDR/RD_DATA       : combinational debug read port
//   A, B, CONTROL         : registered ALU inputs
//   Z, OF, CC             : ALU outputs (result low/high half, flags)
//   CC_REG, OF_REG        : flags / high half of the last retired legal op
//   DONE                  : one-cycle retire pulse (WB state)
//   BUSY                  : state is not IDLE
//   TRAP                  : sticky illegal-op trap (only with the macro)
//
// Optional feature macro: ALU_SEQ_ILLEGAL_TRAP_EN
//   Defined   -> TRAP port exists; an illegal op sets it on the EXEC edge,
//                and while set the block refuses instructions and loads
//                until reset.
//   Undefined -> illegal ops retire silently and operation continues.
// ---------------------------------------------------------------------------
module alu_operand_seq #(
  parameter int unsigned REG_ADDR_W = 3,
  parameter bit          R0_ZERO    = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  input  logic [15:0]           INSTR,
  input  logic                  LD_EN,
  input  logic [REG_ADDR_W-1:0] LD_ADDR,
  input  logic [15:0]           LD_DATA,
  input  logic [REG_ADDR_W-1:0] RD_ADDR,
  output logic [15:0]           RD_DATA,
  output logic [15:0]           A,
  output logic [15:0]           B,
  output logic [3:0]            CONTROL,
  input  logic [15:0]           Z,
  input  logic [15:0]           OF,
  input  logic [2:0]            CC,
  output logic [2:0]            CC_REG,
  output logic [15:0]           OF_REG,
  output logic                  DONE,
  output logic                  BUSY
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  ,
  output logic                  TRAP
`endif
);

  localparam int unsigned DEPTH = 2 ** REG_ADDR_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           a_q, a_d;
  logic [15:0]           b_q, b_d;
  logic [3:0]            ctrl_q, ctrl_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [2:0]            cc_q, cc_d;
  logic [15:0]           of_q, of_d;
  logic [15:0]           regs_q [DEPTH];
  logic [15:0]           regs_d [DEPTH];

  logic                  trap_active;
  logic                  accept;

  // Instruction fields, resized to the register address width.
  logic [3:0]            instr_op;
  logic [REG_ADDR_W-1:0] instr_rd;
  logic [REG_ADDR_W-1:0] instr_rs;
  logic [REG_ADDR_W-1:0] instr_rt;
  logic                  unused_reserved;

  assign instr_op        = INSTR[15:12];
  assign instr_rd        = REG_ADDR_W'(INSTR[11:9]);
  assign instr_rs        = REG_ADDR_W'(INSTR[8:6]);
  assign instr_rt        = REG_ADDR_W'(INSTR[5:3]);
  assign unused_reserved = ^INSTR[2:0];

  // Register read with the hard-wired zero register applied.
  function automatic logic [15:0] rf_read(input logic [REG_ADDR_W-1:0] addr);
    if (R0_ZERO && (addr == '0)) begin
      return '0;
    end
    return regs_q[addr];
  endfunction

  function automatic logic rf_writable(input logic [REG_ADDR_W-1:0] addr);
    return !(R0_ZERO && (addr == '0));
  endfunction

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic trap_q, trap_d;
  assign trap_active = trap_q;
  assign TRAP        = trap_q;
`else
  assign trap_active = 1'b0;
`endif

  // Loads take priority over instructions in IDLE, which is what keeps
  // same-edge reads and writes from ever colliding (no bypass needed).
  assign INSTR_READY = (state_q == IDLE) && !LD_EN && !trap_active;
  assign accept      = INSTR_VALID && INSTR_READY;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    rd_d    = rd_q;
    cc_d    = cc_q;
    of_d    = of_q;
    regs_d  = regs_q;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    trap_d  = trap_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (LD_EN && !trap_active) begin
          if (rf_writable(LD_ADDR)) begin
            regs_d[LD_ADDR] = LD_DATA;
          end
        end else if (accept) begin
          a_d     = rf_read(instr_rs);
          b_d     = rf_read(instr_rt);
          ctrl_d  = instr_op;
          rd_d    = instr_rd;
          state_d = EXEC;
        end
      end

      EXEC: begin
        if (!ctrl_q[3]) begin
          if (rf_writable(rd_q)) begin
            regs_d[rd_q] = Z;
          end
          of_d = OF;
          cc_d = CC;
        end else begin
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
          trap_d = 1'b1;
`endif
        end
        state_d = WB;
      end

      WB: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= '0;
      rd_q    <= '0;
      cc_q    <= '0;
      of_q    <= '0;
      regs_q  <= '{default: '0};
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      rd_q    <= rd_d;
      cc_q    <= cc_d;
      of_q    <= of_d;
      regs_q  <= regs_d;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  assign A       = a_q;
  assign B       = b_q;
  assign CONTROL = ctrl_q;
  assign CC_REG  = cc_q;
  assign OF_REG  = of_q;
  assign RD_DATA = rf_read(RD_ADDR);
  assign DONE    = (state_q == WB);
  assign BUSY    = (state_q != IDLE);

endmodule

// File: tb/tb_alu_operand_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_seq
//   Directed bench for alu_operand_seq with a small combinational ALU model
//   closing the A/B/CONTROL -> Z/OF/CC loop. ALU model: op 0 = add
//   (carry in OF), op 5 = 16x16 multiply (high half in OF), any other op =
//   XOR; CC = {Z==0, OF!=0, Z[15]}.
//   Honours ALU_SEQ_ILLEGAL_TRAP_EN when defined.
// ---------------------------------------------------------------------------
module tb_alu_operand_seq;

  logic        CLK;
  logic        RST_N;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [15:0] INSTR;
  logic        LD_EN;
  logic [2:0]  LD_ADDR;
  logic [15:0] LD_DATA;
  logic [2:0]  RD_ADDR;
  logic [15:0] RD_DATA;
  logic [15:0] A;
  logic [15:0] B;
  logic [3:0]  CONTROL;
  logic [15:0] Z;
  logic [15:0] OF;
  logic [2:0]  CC;
  logic [2:0]  CC_REG;
  logic [15:0] OF_REG;
  logic        DONE;
  logic        BUSY;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic        TRAP;
`endif

  int unsigned passed;
  int unsigned total;

  alu_operand_seq #(
    .REG_ADDR_W(3),
    .R0_ZERO   (1'b1)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY),
    .INSTR      (INSTR),
    .LD_EN      (LD_EN),
    .LD_ADDR    (LD_ADDR),
    .LD_DATA    (LD_DATA),
    .RD_ADDR    (RD_ADDR),
    .RD_DATA    (RD_DATA),
    .A          (A),
    .B          (B),
    .CONTROL    (CONTROL),
    .Z          (Z),
    .OF         (OF),
    .CC         (CC),
    .CC_REG     (CC_REG),
    .OF_REG     (OF_REG),
    .DONE       (DONE),
    .BUSY       (BUSY)
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    ,
    .TRAP       (TRAP)
`endif
  );

  // Combinational ALU model.
  logic [31:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (CONTROL)
      4'd0:    alu_res = 32'(A) + 32'(B);
      4'd5:    alu_res = 32'(A) * 32'(B);
      default: alu_res = 32'(A ^ B);
    endcase
    Z  = alu_res[15:0];
    OF = alu_res[31:16];
    CC = {(Z == 16'h0000), (OF != 16'h0000), Z[15]};
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input logic [2:0] addr, input logic [15:0] data);
    LD_EN   = 1'b1;
    LD_ADDR = addr;
    LD_DATA = data;
    tick();
    LD_EN   = 1'b0;
  endtask

  task automatic pulse_reset();
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
  endtask

  // Issue from IDLE; checks operands in EXEC, DONE and RD_DATA(rd) in WB,
  // and return to IDLE.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [2:0] rd, input logic [2:0] rs,
                        input logic [2:0] rt, input logic [15:0] ea,
                        input logic [15:0] eb, input logic [15:0] ewb);
    INSTR       = {op, rd, rs, rt, 3'b000};
    INSTR_VALID = 1'b1;
    RD_ADDR     = rd;
    tick();
    INSTR_VALID = 1'b0;
    chk({tag, "_exec_A"}, 32'(A), 32'(ea));
    chk({tag, "_exec_B"}, 32'(B), 32'(eb));
    chk({tag, "_exec_CONTROL"}, 32'(CONTROL), 32'(op));
    chk({tag, "_exec_BUSY"}, 32'(BUSY), 32'd1);
    chk({tag, "_exec_DONE"}, 32'(DONE), 32'd0);
    tick();
    chk({tag, "_wb_DONE"}, 32'(DONE), 32'd1);
    chk({tag, "_wb_RD_DATA"}, 32'(RD_DATA), 32'(ewb));
    tick();
    chk({tag, "_idle_DONE"}, 32'(DONE), 32'd0);
    chk({tag, "_idle_BUSY"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    passed      = 0;
    total       = 0;
    RST_N       = 1'b0;
    INSTR_VALID = 1'b0;
    INSTR       = '0;
    LD_EN       = 1'b0;
    LD_ADDR     = '0;
    LD_DATA     = '0;
    RD_ADDR     = '0;

    // Reset state
    tick();
    tick();
    chk("rst_A", 32'(A), 32'h0);
    chk("rst_B", 32'(B), 32'h0);
    chk("rst_CONTROL", 32'(CONTROL), 32'h0);
    chk("rst_CC_REG", 32'(CC_REG), 32'h0);
    chk("rst_OF_REG", 32'(OF_REG), 32'h0);
    chk("rst_DONE", 32'(DONE), 32'h0);
    chk("rst_BUSY", 32'(BUSY), 32'h0);
    RST_N = 1'b1;
    tick();
    chk("rst_INSTR_READY", 32'(INSTR_READY), 32'h1);

    // ADD: 3 + 4 -> r3 = 7, OF 0, CC 000
    load(3'd1, 16'h0003);
    load(3'd2, 16'h0004);
    RD_ADDR = 3'd1;
    #1;
    chk("load_r1", 32'(RD_DATA), 32'h0003);
    run_op("add", 4'd0, 3'd3, 3'd1, 3'd2, 16'h0003, 16'h0004, 16'h0007);
    chk("add_OF_REG", 32'(OF_REG), 32'h0000);
    chk("add_CC_REG", 32'(CC_REG), 32'h0);
    chk("add_READY", 32'(INSTR_READY), 32'h1);

    // MUL: 0x100 * 0x100 = 0x0001_0000 -> r4 = 0, OF 1, CC = 3'b110
    load(3'd1, 16'h0100);
    load(3'd2, 16'h0100);
    run_op("mul", 4'd5, 3'd4, 3'd1, 3'd2, 16'h0100, 16'h0100, 16'h0000);
    chk("mul_OF_REG", 32'(OF_REG), 32'h0001);
    chk("mul_CC_REG", 32'(CC_REG), 32'h6);

    // Illegal op 1000 into r2 = 0x5555: no writeback, status unchanged
    load(3'd2, 16'h5555);
    run_op("ill", 4'd8, 3'd2, 3'd1, 3'd2, 16'h0100, 16'h5555, 16'h5555);
    chk("ill_OF_REG", 32'(OF_REG), 32'h0001);
    chk("ill_CC_REG", 32'(CC_REG), 32'h6);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    chk("ill_TRAP", 32'(TRAP), 32'h1);
    chk("ill_READY_trapped", 32'(INSTR_READY), 32'h0);
    load(3'd7, 16'h7777);
    RD_ADDR = 3'd7;
    #1;
    chk("ill_load_ignored", 32'(RD_DATA), 32'h0000);
    chk("ill_READY_still", 32'(INSTR_READY), 32'h0);
    pulse_reset();
    chk("ill_TRAP_cleared", 32'(TRAP), 32'h0);
`else
    chk("ill_READY", 32'(INSTR_READY), 32'h1);
`endif

    // Reset during EXEC of an ADD to r3
    load(3'd1, 16'h0003);
    load(3'd2, 16'h0004);
    RD_ADDR     = 3'd3;
    INSTR       = {4'd0, 3'd3, 3'd1, 3'd2, 3'b000};
    INSTR_VALID = 1'b1;
    tick();
    INSTR_VALID = 1'b0;
    chk("mid_exec_A", 32'(A), 32'h0003);
    chk("mid_exec_BUSY", 32'(BUSY), 32'h1);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_A", 32'(A), 32'h0);
    chk("mid_rst_B", 32'(B), 32'h0);
    chk("mid_rst_CONTROL", 32'(CONTROL), 32'h0);
    chk("mid_rst_BUSY", 32'(BUSY), 32'h0);
    chk("mid_rst_DONE", 32'(DONE), 32'h0);
    tick();
    RST_N = 1'b1;
    tick();
    chk("mid_r3", 32'(RD_DATA), 32'h0000);
    chk("mid_CC_REG", 32'(CC_REG), 32'h0);
    chk("mid_READY", 32'(INSTR_READY), 32'h1);
    tick();
    chk("mid_no_DONE", 32'(DONE), 32'h0);

    // R0 protection
    load(3'd0, 16'hBEEF);
    RD_ADDR = 3'd0;
    #1;
    chk("r0_after_load", 32'(RD_DATA), 32'h0000);
    load(3'd1, 16'h0001);
    load(3'd2, 16'h0001);
    run_op("r0", 4'd0, 3'd0, 3'd1, 3'd2, 16'h0001, 16'h0001, 16'h0000);
    chk("r0_after_wb", 32'(RD_DATA), 32'h0000);
    chk("r0_CC_REG", 32'(CC_REG), 32'h0);

    // Load / instruction collision in IDLE
    RD_ADDR     = 3'd5;
    LD_EN       = 1'b1;
    LD_ADDR     = 3'd5;
    LD_DATA     = 16'h1234;
    INSTR       = {4'd0, 3'd6, 3'd1, 3'd2, 3'b000};
    INSTR_VALID = 1'b1;
    #1;
    chk("coll_READY_low", 32'(INSTR_READY), 32'h0);
    tick();
    chk("coll_not_accepted", 32'(BUSY), 32'h0);
    chk("coll_r5", 32'(RD_DATA), 32'h1234);
    LD_EN = 1'b0;
    #1;
    chk("coll_READY_high", 32'(INSTR_READY), 32'h1);
    run_op("coll", 4'd0, 3'd6, 3'd1, 3'd2, 16'h0001, 16'h0001, 16'h0002);

    // Load while busy is dropped
    INSTR       = {4'd0, 3'd3, 3'd1, 3'd2, 3'b000};
    INSTR_VALID = 1'b1;
    tick();
    INSTR_VALID = 1'b0;
    LD_EN       = 1'b1;
    LD_ADDR     = 3'd7;
    LD_DATA     = 16'hAAAA;
    #1;
    chk("busy_READY", 32'(INSTR_READY), 32'h0);
    tick();
    LD_EN   = 1'b0;
    RD_ADDR = 3'd7;
    #1;
    chk("busy_load_dropped", 32'(RD_DATA), 32'h0000);
    RD_ADDR = 3'd3;
    #1;
    chk("busy_r3", 32'(RD_DATA), 32'h0002);
    tick();
    chk("busy_idle", 32'(BUSY), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_operand_seq.md
Name: alu_operand_seq

Overview:
Operand sequencer and writeback stage wrapped around the 16-bit ALU. It holds a small register file and accepts one instruction at a time over a valid/ready handshake. It drives the ALU's A, B and CONTROL inputs from registers, then captures Z, OF and CC back into the register file and status registers. The ALU stays purely combinational and sits between this block's A/B/CONTROL outputs and its Z/OF/CC inputs.

Parameters:
REG_ADDR_W, 3, register address width; register file depth is 2**REG_ADDR_W entries of 16 bits.
R0_ZERO, 1, when 1 register 0 reads as 0x0000 and writes to it are discarded.

Ports:
CLK  input  1  single clock, rising edge.
RST_N  input  1  reset, asynchronous, active-low.
INSTR_VALID  input  1  instruction offered.
INSTR_READY  output  1  block accepts the instruction this cycle.
INSTR  input  16  [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] reserved and ignored.
LD_EN  input  1  external register load strobe.
LD_ADDR  input  REG_ADDR_W  load target register.
LD_DATA  input  16  load data.
RD_ADDR  input  REG_ADDR_W  debug read address.
RD_DATA  output  16  combinational read of register RD_ADDR.
A  output  16  ALU port A, registered.
B  output  16  ALU port B, registered.
CONTROL  output  4  ALU control, registered.
Z  input  16  ALU result low half.
OF  input  16  ALU result high half.
CC  input  3  ALU flags.
CC_REG  output  3  latched flags of the last retired legal op.
OF_REG  output  16  latched OF of the last retired legal op.
DONE  output  1  one-cycle pulse when an instruction retires.
BUSY  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE; A, B, CONTROL, CC_REG, OF_REG, DONE and all registers are 0; INSTR_READY becomes 1 once reset is deasserted. Asserting reset during any state aborts the instruction with no writeback.
- States: IDLE -> EXEC -> WB -> IDLE.
- IDLE: INSTR_READY = !LD_EN. If LD_EN is high, write LD_DATA to LD_ADDR; INSTR is not accepted that cycle even if INSTR_VALID is high.
- Accept on (IDLE & INSTR_VALID & INSTR_READY) at a rising edge. On that same edge: A <= reg[rs], B <= reg[rt], CONTROL <= op, latch rd, go to EXEC.
- EXEC: the ALU settles. On the EXEC edge:
  - legal op (op[3]==0): reg[rd] <= Z, OF_REG <= OF, CC_REG <= CC (raw, unmodified).
  - illegal op (op[3]==1): no register, CC_REG or OF_REG update.
  - Either way, go to WB.
- WB: DONE = 1 for exactly one cycle, then IDLE.
- Latency and throughput: DONE is high in the 2nd cycle after the accept edge; the next accept can happen no earlier than the 3rd cycle.
- The written value is visible on RD_DATA during WB.
- A, B and CONTROL hold their values until the next accept.
- LD_EN outside IDLE is ignored; the load is lost and no error is flagged.
- With R0_ZERO=1: RD_DATA and operand reads of address 0 return 0x0000; writeback or load to address 0 is discarded.
- Reads in IDLE see the register contents before any same-edge write; there is no bypass, because loads and accepts are mutually exclusive.

Optional Feature:
ALU_SEQ_ILLEGAL_TRAP_EN:
- Defined: adds output port TRAP (1 bit, reset 0). An illegal op sets TRAP on the EXEC edge. TRAP is sticky until RST_N. While TRAP=1, INSTR_READY=0 and LD_EN is ignored. DONE still pulses for the trapping instruction.
- Undefined: no TRAP port. Illegal ops retire silently with DONE and no writeback, and operation continues normally.

Test Plan:
- Reset mid-op: assert RST_N=0 during EXEC of an ADD to r3 -> immediately A=B=0, CONTROL=0, BUSY=0, DONE=0; after release r3=0x0000, CC_REG=0, INSTR_READY=1.
- ADD with the ALU model: load r1=0x0003, r2=0x0004; issue op=0000 rd=3 rs=1 rt=2 -> A=0x0003, B=0x0004, CONTROL=0000 during EXEC; DONE 2 cycles after accept; r3=0x0007; OF_REG=0x0000.
- MUL: r1=0x0100, r2=0x0100, op=0101 rd=4 -> r4=0x0000, OF_REG=0x0001, CC_REG equals the ALU's CC for 0x00010000.
- R0 protection: load r0=0xBEEF, then ADD rd=0 with operands 0x0001/0x0001 -> RD_DATA(RD_ADDR=0)=0x0000 throughout.
- Collision: LD_EN=1 (r5=0x1234) and INSTR_VALID=1 in the same IDLE cycle -> r5=0x1234, INSTR_READY=0 that cycle, instruction accepted the following cycle.
- Illegal op=1000 rd=2 with r2=0x5555 -> DONE pulses, r2 stays 0x5555, CC_REG and OF_REG unchanged; with ALU_SEQ_ILLEGAL_TRAP_EN: TRAP=1 and INSTR_READY stays 0 until reset.
